// File: rtl/tetris_input_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tetris_input_pkg                                                 |
// | Button indices, command width and button FSM state encoding.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tetris_input_pkg;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_ROT   = 2;
    localparam int BTN_SOFT  = 3;
    localparam int BTN_HARD  = 4;
    localparam int CMD_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_repeat_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_repeat_fsm                                                   |
// | Per-button synchroniser, tick sampling and auto-repeat timing.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module btn_repeat_fsm
    import tetris_input_pkg::*;
#(
    parameter int DAS_TICKS = 15,
    parameter int ARR_TICKS = 4,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic tick_i,
    output logic held_o,
    output logic set_pending_o,
    output logic set_rep_o
);

    localparam int               TMR_W    = width_of(max_int(DAS_TICKS, ARR_TICKS));
    localparam logic [TMR_W-1:0] DAS_LAST = TMR_W'(DAS_TICKS - 1);
    localparam logic [TMR_W-1:0] ARR_LAST = TMR_W'(ARR_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             held_q;
    logic             set_pending_q;
    logic             set_rep_q;
    logic [TMR_W-1:0] timer_q;
    btn_state_e       state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            held_q        <= 1'b0;
            set_pending_q <= 1'b0;
            set_rep_q     <= 1'b0;
            timer_q       <= '0;
            state_q       <= ST_IDLE;
        end else begin
            sync1_q       <= btn_raw_i;
            sync2_q       <= sync1_q;
            set_pending_q <= 1'b0;
            set_rep_q     <= 1'b0;
            if (tick_i) begin
                held_q <= sync2_q;
                // The timer value is compared before it is advanced.
                case (state_q)
                    ST_IDLE: begin
                        if (sync2_q) begin
                            set_pending_q <= 1'b1;
                            timer_q       <= '0;
                            state_q       <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (!sync2_q) begin
                            state_q <= ST_IDLE;
                        end else if (REPEAT_EN) begin
                            if (timer_q == DAS_LAST) begin
                                set_pending_q <= 1'b1;
                                set_rep_q     <= 1'b1;
                                timer_q       <= '0;
                                state_q       <= ST_REPEAT;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (!sync2_q) begin
                            state_q <= ST_IDLE;
                        end else if (timer_q == ARR_LAST) begin
                            set_pending_q <= 1'b1;
                            set_rep_q     <= 1'b1;
                            timer_q       <= '0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign held_o        = held_q;
    assign set_pending_o = set_pending_q;
    assign set_rep_o     = set_rep_q;

endmodule
`default_nettype wire

// File: rtl/move_cmd_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | move_cmd_scheduler                                               |
// | Debounce/auto-repeat for all buttons, arbitrated onto one        |
// | valid/ready command channel. Rev 1.0                             |
// +------------------------------------------------------------------+
module move_cmd_scheduler
    import tetris_input_pkg::*;
#(
    parameter int               N_BTN       = 5,
    parameter int               TICK_DIV    = 1_000_000,
    parameter int               DAS_TICKS   = 15,
    parameter int               ARR_TICKS   = 4,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b01011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [CMD_W-1:0] cmd_id_o,
    output logic             cmd_repeat_o,
    output logic [N_BTN-1:0] held_o
);

    localparam int               PRE_W    = width_of(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam int               RR_N     = BTN_HARD;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick;
    logic [N_BTN-1:0] set_pend, set_rep;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] rep_q, rep_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             cmd_rep_q, cmd_rep_d;
    logic [CMD_W-1:0] cmd_id_q, cmd_id_d;
    logic             out_free;
    logic             grant;
    logic             found;
    logic [1:0]       idx;
    logic [CMD_W-1:0] gnt_id;

    assign tick = (pre_cnt_q == PRE_LAST);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_repeat_fsm #(
            .DAS_TICKS (DAS_TICKS),
            .ARR_TICKS (ARR_TICKS),
            .REPEAT_EN (REPEAT_MASK[gi])
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .btn_raw_i     (btn_raw_i[gi]),
            .tick_i        (tick),
            .held_o        (held_o[gi]),
            .set_pending_o (set_pend[gi]),
            .set_rep_o     (set_rep[gi])
        );
    end

    always_comb begin
        pre_cnt_d   = tick ? '0 : pre_cnt_q + 1'b1;
        out_free    = !cmd_valid_q || cmd_ready_i;
        grant       = 1'b0;
        found       = 1'b0;
        idx         = '0;
        gnt_id      = '0;
        pending_d   = pending_q;
        rep_d       = rep_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        cmd_rep_d   = cmd_rep_q;

        if (out_free && (|pending_q)) begin
            grant = 1'b1;
            if (pending_q[BTN_HARD]) begin
                gnt_id = CMD_W'(BTN_HARD);
            end else begin
                for (int k = 0; k < RR_N; k++) begin
                    idx = rr_ptr_q + 2'(k);
                    if (!found && pending_q[{1'b0, idx}]) begin
                        found  = 1'b1;
                        gnt_id = {1'b0, idx};
                    end
                end
                rr_ptr_d = gnt_id[1:0] + 2'd1;
            end
            pending_d[gnt_id] = 1'b0;
            cmd_valid_d       = 1'b1;
            cmd_id_d          = gnt_id;
            cmd_rep_d         = rep_q[gnt_id];
        end else if (cmd_valid_q && cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end

        // A new event coalesces into an outstanding one unless that one leaves this cycle.
        for (int i = 0; i < N_BTN; i++) begin
            if (set_pend[i] && (!pending_q[i] || (grant && gnt_id == CMD_W'(i)))) begin
                pending_d[i] = 1'b1;
                rep_d[i]     = set_rep[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q   <= '0;
            pending_q   <= '0;
            rep_q       <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_rep_q   <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            pending_q   <= pending_d;
            rep_q       <= rep_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_rep_q   <= cmd_rep_d;
        end
    end

    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_id_o     = cmd_id_q;
    assign cmd_repeat_o = cmd_rep_q;

endmodule
`default_nettype wire

// File: tb/tb_move_cmd_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_move_cmd_scheduler                                            |
// | Directed vector table plus multi-cycle sequences.  Rev 1.0       |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_move_cmd_scheduler;
    import tetris_input_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = 5'h00;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_id;
    logic       cmd_repeat;
    logic [4:0] held;

    move_cmd_scheduler #(
        .N_BTN       (5),
        .TICK_DIV    (TD),
        .DAS_TICKS   (3),
        .ARR_TICKS   (2),
        .REPEAT_MASK (5'b01011)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw_i    (btn_raw),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (cmd_ready),
        .cmd_id_o     (cmd_id),
        .cmd_repeat_o (cmd_repeat),
        .held_o       (held)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int rep; int cyc; } hs_t;
    typedef struct { int id; int rep; int dly; } exp_t;
    typedef struct { logic [4:0] btn; int ticks; int first; int n; } vec_t;

    hs_t  hs_q[$];
    exp_t et[$];
    vec_t vt[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && cmd_valid && cmd_ready)
            hs_q.push_back('{int'(cmd_id), int'(cmd_repeat), cyc});

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reset leaves the prescaler at 0, so the press sequence starts right after.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        btn_raw = 5'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hs_q.delete();
    endtask

    task automatic run_press(input logic [4:0] mask, input int ticks);
        btn_raw = mask;
        repeat (ticks * TD) @(posedge clk);
        #1;
        btn_raw = 5'h00;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic compare_exp(input string nm, input int first, input int n);
        check({nm, "_count"}, hs_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < hs_q.size()) begin
                check($sformatf("%s_id%0d", nm, k), hs_q[k].id, et[first+k].id);
                check($sformatf("%s_rep%0d", nm, k), hs_q[k].rep, et[first+k].rep);
                check($sformatf("%s_dly%0d", nm, k), hs_q[k].cyc - hs_q[0].cyc, et[first+k].dly);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected command lists: {id, repeat, cycles after first handshake}
        et.push_back('{BTN_LEFT, 0, 0});                                     // 0
        et.push_back('{BTN_LEFT, 0, 0});  et.push_back('{BTN_LEFT, 1, 12});  // 1
        et.push_back('{BTN_LEFT, 1, 20}); et.push_back('{BTN_LEFT, 1, 28});
        et.push_back('{BTN_LEFT, 1, 36});
        et.push_back('{BTN_ROT, 0, 0});                                      // 6
        et.push_back('{BTN_HARD, 0, 0});                                     // 7
        et.push_back('{BTN_RIGHT, 0, 0}); et.push_back('{BTN_RIGHT, 1, 12}); // 8
        et.push_back('{BTN_SOFT, 0, 0});  et.push_back('{BTN_SOFT, 1, 12});  // 10
        et.push_back('{BTN_SOFT, 1, 20});
        et.push_back('{BTN_LEFT, 0, 0});  et.push_back('{BTN_RIGHT, 0, 1});  // 13
        et.push_back('{BTN_ROT, 0, 2});
        et.push_back('{BTN_HARD, 0, 0});  et.push_back('{BTN_LEFT, 0, 1});   // 16
        et.push_back('{BTN_RIGHT, 0, 2}); et.push_back('{BTN_ROT, 0, 3});
        et.push_back('{BTN_SOFT, 0, 4});
        et.push_back('{BTN_HARD, 0, 0});  et.push_back('{BTN_LEFT, 0, 1});   // 21
        et.push_back('{BTN_RIGHT, 0, 2});
        et.push_back('{BTN_LEFT, 0, 0});  et.push_back('{BTN_LEFT, 1, 1});   // 24

        vt.push_back('{5'b00001, 1, 0, 1});
        vt.push_back('{5'b00001, 10, 1, 5});
        vt.push_back('{5'b00100, 10, 6, 1});
        vt.push_back('{5'b10000, 10, 7, 1});
        vt.push_back('{5'b00010, 4, 8, 2});
        vt.push_back('{5'b01000, 6, 10, 3});
        vt.push_back('{5'b00111, 1, 13, 3});

        // Reset with every button down, then a one-tick press of all five.
        rst = 1'b1;
        btn_raw = 5'h1F;
        cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_valid", cmd_valid, 0);
            check("rst_held", held, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        hs_q.delete();
        repeat (TD) @(posedge clk);
        #1;
        check("held_all", held, 5'h1F);
        btn_raw = 5'h00;
        repeat (24) @(posedge clk);
        #1;
        compare_exp("all5", 16, 5);
        check("held_released", held, 0);

        for (int v = 0; v < vt.size(); v++) begin
            do_reset();
            cmd_ready = 1'b1;
            run_press(vt[v].btn, vt[v].ticks);
            compare_exp($sformatf("vec%0d", v), vt[v].first, vt[v].n);
        end

        // Same-tick press of left, right and hard drop.
        do_reset();
        cmd_ready = 1'b1;
        run_press(5'b10011, 1);
        compare_exp("multi", 21, 3);
        check("rr_ptr", dut.rr_ptr_q, 2);

        // One-cycle glitch between ticks must never be sampled.
        do_reset();
        cmd_ready = 1'b1;
        btn_raw = 5'b00100;
        @(posedge clk); #1;
        btn_raw = 5'h00;
        repeat (24) @(posedge clk);
        #1;
        check("glitch_count", hs_q.size(), 0);
        check("glitch_held", held, 0);

        // Back-pressure: output must hold while a repeat coalesces behind it.
        do_reset();
        cmd_ready = 1'b0;
        btn_raw = 5'b00001;
        repeat (2 * TD) @(posedge clk);
        #1;
        check("stall_valid_a", cmd_valid, 1);
        check("stall_id_a", cmd_id, BTN_LEFT);
        check("stall_rep_a", cmd_repeat, 0);
        repeat (4 * TD) @(posedge clk);
        #1;
        check("stall_valid_b", cmd_valid, 1);
        check("stall_rep_b", cmd_repeat, 0);
        btn_raw = 5'h00;
        repeat (8) @(posedge clk);
        #1;
        check("stall_valid_c", cmd_valid, 1);
        check("stall_id_c", cmd_id, BTN_LEFT);
        cmd_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        compare_exp("stall", 24, 2);
        check("stall_idle", cmd_valid, 0);

        // Reset while a command and a repeat are outstanding drops both.
        do_reset();
        cmd_ready = 1'b0;
        btn_raw = 5'b00001;
        repeat (5 * TD) @(posedge clk);
        #1;
        btn_raw = 5'h00;
        check("rstmid_valid_pre", cmd_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_valid_post", cmd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        hs_q.delete();
        cmd_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check("rstmid_count", hs_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
